// File: rtl/fwd_table_ram_arbiter.sv
// Shares the forward-table RAM between fixed-latency lookup reads and handshaked config accesses.
// Optional power-up zero sweep of the table is enabled by defining FWD_TABLE_INIT_EN.
module fwd_table_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 34,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lkp_rd,
  input  logic [ADDR_W-1:0] iv_lkp_raddr,
  output logic [DATA_W-1:0] ov_lkp_rdata,
  output logic              o_lkp_rdata_valid,
  input  logic              i_cfg_wr,
  input  logic              i_cfg_rd,
  input  logic [ADDR_W-1:0] iv_cfg_addr,
  input  logic [DATA_W-1:0] iv_cfg_wdata,
  output logic              o_cfg_ack,
  output logic [DATA_W-1:0] ov_cfg_rdata,
  output logic              o_cfg_rdata_valid,
  output logic [ADDR_W-1:0] ov_ram_addr,
  output logic [DATA_W-1:0] ov_ram_wdata,
  output logic              o_ram_wr,
  output logic              o_ram_rd,
  input  logic [DATA_W-1:0] iv_ram_rdata,
  output logic              o_init_done
);

  logic              lkp_gnt;
  logic              wr_gnt;
  logic              rd_gnt;
  logic              init_gnt;
  logic              run;
  logic              cfg_rd_out;
  logic [ADDR_W-1:0] init_addr;
  logic [RD_LAT:0]   tag_lkp;
  logic [RD_LAT:0]   tag_cfg;

`ifdef FWD_TABLE_INIT_EN
  localparam logic [0:0] INIT_S = 1'b0;
  localparam logic [0:0] RUN_S  = 1'b1;

  logic [0:0] state;
  logic       init_done_q;

  assign run         = init_done_q;
  assign init_gnt    = (state == INIT_S) && !i_lkp_rd;
  assign o_init_done = init_done_q;

  // Config is held off until init_done is visible, so no ack can precede it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= INIT_S;
      init_addr   <= '0;
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= (state == RUN_S);
      if (init_gnt) begin
        init_addr <= init_addr + 1'b1;
        if (init_addr == {ADDR_W{1'b1}})
          state <= RUN_S;
      end
    end
  end
`else
  assign run         = 1'b1;
  assign init_gnt    = 1'b0;
  assign init_addr   = '0;
  assign o_init_done = 1'b1;
`endif

  always_comb begin
    lkp_gnt = i_lkp_rd;
    wr_gnt  = !i_lkp_rd && run && !o_cfg_ack && i_cfg_wr;
    rd_gnt  = !i_lkp_rd && run && !o_cfg_ack && !i_cfg_wr && i_cfg_rd && !cfg_rd_out;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_ram_addr       <= '0;
      ov_ram_wdata      <= '0;
      o_ram_wr          <= 1'b0;
      o_ram_rd          <= 1'b0;
      o_cfg_ack         <= 1'b0;
      tag_lkp           <= '0;
      tag_cfg           <= '0;
      cfg_rd_out        <= 1'b0;
      ov_lkp_rdata      <= '0;
      o_lkp_rdata_valid <= 1'b0;
      ov_cfg_rdata      <= '0;
      o_cfg_rdata_valid <= 1'b0;
    end else begin
      o_ram_rd  <= lkp_gnt || rd_gnt;
      o_ram_wr  <= wr_gnt || init_gnt;
      o_cfg_ack <= wr_gnt || rd_gnt;

      if (lkp_gnt)
        ov_ram_addr <= iv_lkp_raddr;
      else if (wr_gnt || rd_gnt)
        ov_ram_addr <= iv_cfg_addr;
      else if (init_gnt)
        ov_ram_addr <= init_addr;

      if (wr_gnt)
        ov_ram_wdata <= iv_cfg_wdata;
      else if (init_gnt)
        ov_ram_wdata <= '0;

      // Stage RD_LAT lines up with the cycle the RAM presents the data.
      tag_lkp <= {tag_lkp[RD_LAT-1:0], lkp_gnt};
      tag_cfg <= {tag_cfg[RD_LAT-1:0], rd_gnt};

      o_lkp_rdata_valid <= tag_lkp[RD_LAT];
      if (tag_lkp[RD_LAT])
        ov_lkp_rdata <= iv_ram_rdata;

      o_cfg_rdata_valid <= tag_cfg[RD_LAT];
      if (tag_cfg[RD_LAT])
        ov_cfg_rdata <= iv_ram_rdata;

      if (rd_gnt)
        cfg_rd_out <= 1'b1;
      else if (tag_cfg[RD_LAT])
        cfg_rd_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fwd_table_ram_arbiter.sv
// Directed bench for fwd_table_ram_arbiter (default build) with a 2-cycle RAM model.
module tb_fwd_table_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        lkp_rd;
  logic [11:0] lkp_raddr;
  logic [33:0] lkp_rdata;
  logic        lkp_rdata_valid;
  logic        cfg_wr;
  logic        cfg_rd;
  logic [11:0] cfg_addr;
  logic [33:0] cfg_wdata;
  logic        cfg_ack;
  logic [33:0] cfg_rdata;
  logic        cfg_rdata_valid;
  logic [11:0] ram_addr;
  logic [33:0] ram_wdata;
  logic        ram_wr;
  logic        ram_rd;
  logic [33:0] ram_rdata;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  always #4 clk = ~clk;

  fwd_table_ram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_lkp_rd(lkp_rd), .iv_lkp_raddr(lkp_raddr),
    .ov_lkp_rdata(lkp_rdata), .o_lkp_rdata_valid(lkp_rdata_valid),
    .i_cfg_wr(cfg_wr), .i_cfg_rd(cfg_rd), .iv_cfg_addr(cfg_addr), .iv_cfg_wdata(cfg_wdata),
    .o_cfg_ack(cfg_ack), .ov_cfg_rdata(cfg_rdata), .o_cfg_rdata_valid(cfg_rdata_valid),
    .ov_ram_addr(ram_addr), .ov_ram_wdata(ram_wdata), .o_ram_wr(ram_wr), .o_ram_rd(ram_rd),
    .iv_ram_rdata(ram_rdata), .o_init_done(init_done)
  );

  // RAM model: read data appears two cycles after the read-enable cycle.
  logic [33:0] mem [0:4095];
  logic [33:0] rd_p1;
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [33:0] pl_dat = '0;

  always @(posedge clk) begin
    if (pl_we)
      mem[pl_addr] <= pl_dat;
    else if (ram_wr)
      mem[ram_addr] <= ram_wdata;
    rd_p1     <= mem[ram_addr];
    ram_rdata <= rd_p1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [33:0] d);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; lkp_rd = 1'b0; lkp_raddr = '0;
    cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) step();
    chk("rst_ram_rd", ram_rd, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_lkp_valid", lkp_rdata_valid, 0);
    chk("rst_cfg_valid", cfg_rdata_valid, 0);
    chk("rst_init_done", init_done, 1);
    rst = 1'b0;

    preload(12'h123, 34'h2_0000_0005);
    preload(12'h200, 34'h0_1234_5678);
    for (int k = 0; k < 8; k++) preload(12'h300 + 12'(k), 34'h1_0000_0300 + 34'(k));
    preload(12'h400, 34'h0_AAAA_0400);
    preload(12'h401, 34'h3_5555_0401);
    step();

    // Single lookup, latency 4
    lkp_rd = 1'b1; lkp_raddr = 12'h123;
    step(); lkp_rd = 1'b0;
    chk("sl_ram_rd", ram_rd, 1);
    chk("sl_ram_addr", ram_addr, 12'h123);
    step(); chk("sl_valid_c2", lkp_rdata_valid, 0);
    step(); chk("sl_valid_c3", lkp_rdata_valid, 0);
    step();
    chk("sl_valid_c4", lkp_rdata_valid, 1);
    chk("sl_data", lkp_rdata, 34'h2_0000_0005);
    chk("sl_cfg_valid", cfg_rdata_valid, 0);
    step(); chk("sl_valid_pulse", lkp_rdata_valid, 0);

    // Config write, then read-back
    cfg_wr = 1'b1; cfg_addr = 12'h010; cfg_wdata = 34'h1_DEAD_BEEF;
    step(); cfg_wr = 1'b0;
    chk("cw_ram_wr", ram_wr, 1);
    chk("cw_ram_rd", ram_rd, 0);
    chk("cw_ack", cfg_ack, 1);
    chk("cw_addr", ram_addr, 12'h010);
    chk("cw_wdata", ram_wdata, 34'h1_DEAD_BEEF);
    cfg_addr = 12'h7FF;
    step();
    chk("idle_ram_wr", ram_wr, 0);
    chk("idle_ack", cfg_ack, 0);
    chk("idle_addr_hold", ram_addr, 12'h010);
    cfg_rd = 1'b1; cfg_addr = 12'h010;
    step(); cfg_rd = 1'b0;
    chk("cr_ack", cfg_ack, 1);
    chk("cr_ram_rd", ram_rd, 1);
    step(); chk("cr_valid_c2", cfg_rdata_valid, 0);
    step(); chk("cr_valid_c3", cfg_rdata_valid, 0);
    step();
    chk("cr_valid_c4", cfg_rdata_valid, 1);
    chk("cr_data", cfg_rdata, 34'h1_DEAD_BEEF);
    chk("cr_lkp_valid", lkp_rdata_valid, 0);
    step();

    // Ack blanking: request held past its ack reissues after a gap cycle
    cfg_wr = 1'b1; cfg_addr = 12'h050; cfg_wdata = 34'h0_0000_0050;
    step(); chk("ab_ack1", cfg_ack, 1);
    step(); chk("ab_gap", cfg_ack, 0);
    chk("ab_gap_wr", ram_wr, 0);
    step(); chk("ab_ack2", cfg_ack, 1);
    cfg_wr = 1'b0;
    step();

    // Contention: lookup beats config write
    lkp_rd = 1'b1; lkp_raddr = 12'h200;
    cfg_wr = 1'b1; cfg_addr = 12'h020; cfg_wdata = 34'h3_0000_0001;
    step(); lkp_rd = 1'b0;
    chk("ct_ram_rd", ram_rd, 1);
    chk("ct_ram_wr", ram_wr, 0);
    chk("ct_ack_late", cfg_ack, 0);
    chk("ct_addr_lkp", ram_addr, 12'h200);
    step(); cfg_wr = 1'b0;
    chk("ct_ram_wr2", ram_wr, 1);
    chk("ct_ack", cfg_ack, 1);
    chk("ct_addr_cfg", ram_addr, 12'h020);
    step(); chk("ct_valid_c3", lkp_rdata_valid, 0);
    step();
    chk("ct_valid_c4", lkp_rdata_valid, 1);
    chk("ct_data", lkp_rdata, 34'h0_1234_5678);
    step();

    // Eight back-to-back lookups starve a held config read
    cfg_rd = 1'b1; cfg_addr = 12'h010;
    lkp_rd = 1'b1; lkp_raddr = 12'h300;
    for (int c = 1; c <= 13; c++) begin
      step();
      lkp_rd = (c <= 7);
      lkp_raddr = 12'h300 + 12'(c);
      if (c <= 8) chk("bb_ram_addr", ram_addr, 12'h300 + 12'(c - 1));
      chk("bb_ack", cfg_ack, (c == 9));
      if (c == 9) begin
        chk("bb_cfg_addr", ram_addr, 12'h010);
        cfg_rd = 1'b0;
      end
      if (c >= 4 && c <= 11) begin
        chk("bb_lkp_valid", lkp_rdata_valid, 1);
        chk("bb_lkp_data", lkp_rdata, 34'h1_0000_0300 + 34'(c - 4));
      end else begin
        chk("bb_lkp_idle", lkp_rdata_valid, 0);
      end
      chk("bb_cfg_valid", cfg_rdata_valid, (c == 12));
      if (c == 12) chk("bb_cfg_data", cfg_rdata, 34'h1_DEAD_BEEF);
    end

    // Interleave: lookup, config read, lookup in consecutive RAM cycles
    lkp_rd = 1'b1; lkp_raddr = 12'h400;
    cfg_rd = 1'b1; cfg_addr = 12'h020;
    step(); lkp_rd = 1'b0;
    chk("il_addr_a", ram_addr, 12'h400);
    step();
    chk("il_ack", cfg_ack, 1);
    chk("il_addr_cfg", ram_addr, 12'h020);
    chk("il_rd_cfg", ram_rd, 1);
    cfg_rd = 1'b0; lkp_rd = 1'b1; lkp_raddr = 12'h401;
    step(); lkp_rd = 1'b0;
    chk("il_addr_b", ram_addr, 12'h401);
    step();
    chk("il_a_valid", lkp_rdata_valid, 1);
    chk("il_a_data", lkp_rdata, 34'h0_AAAA_0400);
    chk("il_a_cfg_quiet", cfg_rdata_valid, 0);
    step();
    chk("il_c_valid", cfg_rdata_valid, 1);
    chk("il_c_data", cfg_rdata, 34'h3_0000_0001);
    chk("il_c_lkp_quiet", lkp_rdata_valid, 0);
    step();
    chk("il_b_valid", lkp_rdata_valid, 1);
    chk("il_b_data", lkp_rdata, 34'h3_5555_0401);
    chk("il_b_cfg_quiet", cfg_rdata_valid, 0);
    step();

    // Simultaneous write and read: write first, read after blanking cycle
    cfg_wr = 1'b1; cfg_rd = 1'b1; cfg_addr = 12'h030; cfg_wdata = 34'h2_AAAA_5555;
    step(); cfg_wr = 1'b0;
    chk("wr_first_wr", ram_wr, 1);
    chk("wr_first_rd", ram_rd, 0);
    chk("wr_first_ack", cfg_ack, 1);
    step(); chk("wr_blank_ack", cfg_ack, 0);
    step(); cfg_rd = 1'b0;
    chk("rd_second_ack", cfg_ack, 1);
    chk("rd_second_rd", ram_rd, 1);
    step(); step(); step();
    chk("rd_second_valid", cfg_rdata_valid, 1);
    chk("rd_second_data", cfg_rdata, 34'h2_AAAA_5555);
    step();

    // Reset with reads in flight drops them
    lkp_rd = 1'b1; lkp_raddr = 12'h123;
    cfg_rd = 1'b1; cfg_addr = 12'h010;
    step(); lkp_rd = 1'b0; cfg_rd = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    chk("mr_ram_rd", ram_rd, 0);
    chk("mr_ack", cfg_ack, 0);
    chk("mr_ram_addr", ram_addr, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mr_lkp_valid", lkp_rdata_valid, 0);
      chk("mr_cfg_valid", cfg_rdata_valid, 0);
    end
    cfg_rd = 1'b1; cfg_addr = 12'h010;
    step(); cfg_rd = 1'b0;
    chk("mr_cfg_after", cfg_ack, 1);
    step(); step(); step();
    chk("mr_cfg_data", cfg_rdata, 34'h1_DEAD_BEEF);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_table_ram_arbiter.md
Name: fwd_table_ram_arbiter

Overview:
- Shares the single TSMP forward-table RAM (4096 x 34b) between the MID lookup read path and the host configuration path (writes and readback).
- Sits between the MID lookup logic, the config/CSR agent and the RAM.
- Lookup reads always win and keep a fixed latency. Config accesses fill idle RAM cycles through a request/ack handshake.
- Read data is routed back to whichever requester issued the read, using a source-tag pipeline.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 34, RAM data width.
- RD_LAT, 2, RAM read latency in cycles, from o_ram_rd to a valid iv_ram_rdata.

Ports:
- i_clk  in  1  125 MHz clock.
- i_rst  in  1  synchronous, active-high reset.
- i_lkp_rd  in  1  lookup read strobe, single-cycle pulse.
- iv_lkp_raddr  in  ADDR_W  lookup read address.
- ov_lkp_rdata  out  DATA_W  lookup read data.
- o_lkp_rdata_valid  out  1  lookup read data valid, 1-cycle pulse.
- i_cfg_wr  in  1  config write request, level, held until ack.
- i_cfg_rd  in  1  config read request, level, held until ack.
- iv_cfg_addr  in  ADDR_W  config address.
- iv_cfg_wdata  in  DATA_W  config write data.
- o_cfg_ack  out  1  config request granted, 1-cycle pulse.
- ov_cfg_rdata  out  DATA_W  config readback data.
- o_cfg_rdata_valid  out  1  config readback valid, 1-cycle pulse.
- ov_ram_addr  out  ADDR_W  RAM address.
- ov_ram_wdata  out  DATA_W  RAM write data.
- o_ram_wr  out  1  RAM write enable.
- o_ram_rd  out  1  RAM read enable.
- iv_ram_rdata  in  DATA_W  RAM read data.
- o_init_done  out  1  table ready; tied to 1 unless FWD_TABLE_INIT_EN is defined.

Behaviour:
- Only one clock and one reset are used. Reset is synchronous and active-high.
- Reset values:
  - All outputs are 0, except o_init_done = 1 when FWD_TABLE_INIT_EN is undefined.
  - Tag pipeline is cleared and the config-read-outstanding flag is cleared.
- All RAM-side and requester-side outputs are registered.
- Arbitration in cycle t, evaluated in priority order:
  1. i_lkp_rd = 1: lookup granted.
  2. else i_cfg_wr = 1 and o_cfg_ack = 0: config write granted.
  3. else i_cfg_rd = 1, o_cfg_ack = 0 and no config read outstanding: config read granted.
  4. else the RAM is idle.
- Lookup grant:
  - In t+1: o_ram_rd = 1 and ov_ram_addr = iv_lkp_raddr.
  - A tag "LKP" enters an (RD_LAT+1)-deep tag shift register.
  - In t+2+RD_LAT: ov_lkp_rdata = iv_ram_rdata sampled at t+1+RD_LAT, and o_lkp_rdata_valid = 1.
  - Total latency is RD_LAT+2 cycles (4 at default), fixed and independent of config traffic.
- Config write grant: in t+1, o_ram_wr = 1, ov_ram_addr / ov_ram_wdata are driven from the config inputs, and o_cfg_ack = 1.
- Config read grant:
  - In t+1: o_ram_rd = 1 and o_cfg_ack = 1; tag "CFG" enters the tag pipe; the outstanding flag is set.
  - ov_cfg_rdata and o_cfg_rdata_valid follow at t+2+RD_LAT; the outstanding flag clears in that same cycle.
- Ack blanking: when o_cfg_ack = 1, the config request is ignored in that cycle. The requester must deassert in the cycle it sees the ack, otherwise a new access is issued one cycle later.
- Simultaneous i_cfg_wr and i_cfg_rd: the write is served first; the read stays pending.
- Idle cycle: o_ram_rd = 0 and o_ram_wr = 0. ov_ram_addr and ov_ram_wdata hold their last values.
- o_ram_rd and o_ram_wr are never both 1 in the same cycle.
- Back-to-back lookups are accepted every cycle. Each returns in order at the fixed latency.
- The arbiter applies no address-hazard logic; RAM read-during-write behaviour applies.
- Reset mid-operation: in-flight reads are dropped, and no rdata_valid is asserted after reset.

Optional Feature:
- Macro: FWD_TABLE_INIT_EN.
- When defined, the block powers up into INIT_S after reset:
  - It sweeps addresses 0..2^ADDR_W-1, writing all-zero data, one write per cycle.
  - The sweep pauses in any cycle where a lookup is granted.
  - Config requests are not acked during the sweep.
  - o_init_done = 0 during the sweep and rises one cycle after the write to address 4095 is issued, entering RUN_S.
- When undefined, the block starts directly in RUN_S and o_init_done is constant 1.

Test Plan:
- Single lookup: i_lkp_rd with addr 0x123; RAM returns 0x2_0000_0005 → o_ram_rd at +1; o_lkp_rdata_valid at +4 with data 0x2_0000_0005; o_cfg_rdata_valid stays 0.
- Config write then read-back:
  - Write addr 0x010, data 0x1_DEAD_BEEF → o_ram_wr pulse and o_cfg_ack.
  - Read addr 0x010 → o_cfg_ack, then o_cfg_rdata_valid 3 cycles later with 0x1_DEAD_BEEF.
- Contention:
  - i_lkp_rd and i_cfg_wr asserted in the same cycle → lookup issued first; config write issued the next cycle; ack 1 cycle later than the uncontended case.
  - Lookup latency is still 4.
- Lookups every cycle for 8 cycles with i_cfg_rd held → no cfg ack for 8 cycles; 8 lookup valids in address order; cfg read then granted.
- Interleaving: lookup read, config read and lookup read in consecutive RAM cycles → data is routed to the correct ports in order; no cross-delivery.
- FWD_TABLE_INIT_EN:
  - After reset, o_init_done rises after 4097 cycles with no lookups.
  - A lookup at cycle 100 extends the sweep by 1 cycle.
  - A config write during the sweep is acked only after o_init_done = 1.
